// File: rtl/buscaminas_pkg.sv
// Shared types, cell layout and neighbour helper for the minesweeper board engine.
package buscaminas_pkg;
  localparam int          BOARD_N      = 8;
  localparam int          MINE_B       = 6;
  localparam int          FLAG_B       = 5;
  localparam int          REV_B        = 4;
  localparam int          CNT_MSB      = 3;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef logic [6:0] cell_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_PLACE, S_COUNT, S_PLAY, S_FLOOD, S_WIN, S_LOSE
  } state_t;

  // k-th neighbour (k=0..7, raster order) of cell (r,c); returns 1 when it lies on the board.
  // The offset is added in 5 bits so that leaving the board shows up in bits [4:3].
  function automatic logic nb_at(input logic [2:0] r, input logic [2:0] c, input logic [2:0] k,
                                 output logic [2:0] nr, output logic [2:0] nc);
    logic [4:0] dr, dc, tr, tc;
    case (k)
      3'd0:    begin dr = 5'h1f; dc = 5'h1f; end
      3'd1:    begin dr = 5'h1f; dc = 5'h00; end
      3'd2:    begin dr = 5'h1f; dc = 5'h01; end
      3'd3:    begin dr = 5'h00; dc = 5'h1f; end
      3'd4:    begin dr = 5'h00; dc = 5'h01; end
      3'd5:    begin dr = 5'h01; dc = 5'h1f; end
      3'd6:    begin dr = 5'h01; dc = 5'h00; end
      default: begin dr = 5'h01; dc = 5'h01; end
    endcase
    tr = {2'b00, r} + dr;
    tc = {2'b00, c} + dc;
    nr = tr[2:0];
    nc = tc[2:0];
    return (tr[4:3] == 2'b00) && (tc[4:3] == 2'b00);
  endfunction
endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11. Load wins over enable.
module lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  logic [15:0] r_q;

  // state register: load seed or shift in the tap parity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= 16'h0001;
    else if (load) r_q <= seed;
    else if (en)   r_q <= {r_q[14:0], r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10]};
  end

  assign q = r_q;
endmodule

// File: rtl/tablero_ctrl.sv
// Minesweeper game-state engine: mine placement, neighbour counts, cursor,
// reveal/flag handling and multi-pass flood reveal of zero regions.
module tablero_ctrl #(
  parameter int          BOARD_N      = 8,
  parameter int          MAX_MINAS    = 10,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 use_map,
  input  logic [63:0]          mine_map,
  input  logic [15:0]          seed,
  input  logic [5:0]           num_minas,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_reveal,
  input  logic                 btn_flag,
  output logic [7:0][7:0][6:0] tablero,
  output logic [2:0]           i_actual,
  output logic [2:0]           j_actual,
  output logic                 enable_derrota,
  output logic                 enable_victoria,
  output logic                 busy
);
  import buscaminas_pkg::*;

  localparam int         NCELLS = BOARD_N * BOARD_N;
  localparam logic [5:0] MAXM   = 6'(MAX_MINAS);

  state_t               r_state, w_nxt;
  logic [7:0][7:0][6:0] r_board;
  logic [2:0]           r_i, r_j;
  logic                 r_derrota, r_victoria;
  logic [6:0]           r_rev, r_mines;
  logic [3:0]           r_placed, r_target;
  logic [6:0]           r_idx;      // scan index; bit6 marks the end-of-pass cycle
  logic                 r_chg;      // a flood pass revealed something
  logic                 r_use_map;
  logic [63:0]          r_map;
  logic [15:0]          r_seed;

  logic [15:0]          w_lfsr;
  logic                 w_unused_lfsr;
  cell_t                w_cur;
  logic [2:0]           w_sr, w_sc;
  logic [7:0]           w_nb_v, w_fmask;
  logic [7:0][2:0]      w_nb_r, w_nb_c;
  logic [3:0]           w_cnt, w_fcnt;
  logic                 w_flood_src, w_rev_ok, w_win_play, w_win_flood;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (r_state == S_CLEAR),
    .en    (r_state == S_PLACE),
    .seed  (r_seed),
    .q     (w_lfsr)
  );

  // only the low 6 bits pick a cell
  assign w_unused_lfsr = ^w_lfsr[15:6];

  assign w_sr        = r_idx[5:3];
  assign w_sc        = r_idx[2:0];
  assign w_cur       = r_board[r_i][r_j];
  assign w_rev_ok    = btn_reveal && !w_cur[REV_B] && !w_cur[FLAG_B];
  assign w_win_play  = (r_rev + 7'd1) == (7'(NCELLS) - r_mines);
  assign w_win_flood = r_rev == (7'(NCELLS) - r_mines);
  assign w_flood_src = r_board[w_sr][w_sc][REV_B] && !r_board[w_sr][w_sc][MINE_B] &&
                       (r_board[w_sr][w_sc][CNT_MSB:0] == 4'd0);

  // neighbours of the scanned cell: mine count for COUNT, reveal mask for FLOOD
  always_comb begin
    logic [2:0] tr, tc;
    tr      = '0;
    tc      = '0;
    w_nb_v  = '0;
    w_nb_r  = '0;
    w_nb_c  = '0;
    w_cnt   = '0;
    w_fmask = '0;
    w_fcnt  = '0;
    for (int k = 0; k < 8; k++) begin
      w_nb_v[k] = nb_at(w_sr, w_sc, 3'(k), tr, tc);
      w_nb_r[k] = tr;
      w_nb_c[k] = tc;
      if (w_nb_v[k] && r_board[tr][tc][MINE_B]) w_cnt = w_cnt + 4'd1;
      if (w_nb_v[k] && w_flood_src && (r_board[tr][tc][6:4] == 3'b000)) begin
        w_fmask[k] = 1'b1;
        w_fcnt     = w_fcnt + 4'd1;
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // next-state logic; start overrides everything
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_CLEAR: w_nxt = r_use_map ? S_COUNT : S_PLACE;
      S_PLACE: if (r_placed == r_target) w_nxt = S_COUNT;
      S_COUNT: if (r_idx[6]) w_nxt = S_PLAY;
      S_PLAY: begin
        if (w_rev_ok) begin
          if (w_cur[MINE_B])                   w_nxt = S_LOSE;
          else if (w_cur[CNT_MSB:0] == 4'd0)   w_nxt = S_FLOOD;
          else if (w_win_play)                 w_nxt = S_WIN;
        end
      end
      S_FLOOD: if (r_idx[6] && !r_chg) w_nxt = w_win_flood ? S_WIN : S_PLAY;
      default: w_nxt = r_state;
    endcase
    if (start) w_nxt = S_CLEAR;
  end

  // board, cursor, counters and indicators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_board    <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_derrota  <= 1'b0;
      r_victoria <= 1'b0;
      r_rev      <= '0;
      r_mines    <= '0;
      r_placed   <= '0;
      r_target   <= 4'd1;
      r_idx      <= '0;
      r_chg      <= 1'b0;
      r_use_map  <= 1'b0;
      r_map      <= '0;
      r_seed     <= DEFAULT_SEED;
    end else if (start) begin
      r_use_map  <= use_map;
      r_map      <= mine_map;
      r_seed     <= (seed == 16'h0) ? DEFAULT_SEED : seed;
      r_target   <= (num_minas == 6'd0) ? 4'd1 :
                    (num_minas > MAXM)  ? MAXM[3:0] : num_minas[3:0];
      r_derrota  <= 1'b0;
      r_victoria <= 1'b0;
      r_rev      <= '0;
      r_i        <= '0;
      r_j        <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
              r_board[r][c] <= {r_use_map & r_map[r*8+c], 6'b0};
          r_mines  <= r_use_map ? 7'($countones(r_map)) : {3'b000, r_target};
          r_placed <= '0;
          r_idx    <= '0;
          r_chg    <= 1'b0;
        end
        S_PLACE: begin
          if (r_placed != r_target && !r_board[w_lfsr[5:3]][w_lfsr[2:0]][MINE_B]) begin
            r_board[w_lfsr[5:3]][w_lfsr[2:0]][MINE_B] <= 1'b1;
            r_placed <= r_placed + 4'd1;
          end
        end
        S_COUNT: begin
          if (!r_idx[6]) begin
            r_board[w_sr][w_sc][CNT_MSB:0] <= w_cnt;
            r_idx <= r_idx + 7'd1;
          end
        end
        S_PLAY: begin
          if (btn_reveal) begin
            if (w_rev_ok) begin
              r_board[r_i][r_j][REV_B] <= 1'b1;
              if (w_cur[MINE_B]) r_derrota <= 1'b1;
              else begin
                r_rev <= r_rev + 7'd1;
                if (w_cur[CNT_MSB:0] == 4'd0) begin
                  r_idx <= '0;
                  r_chg <= 1'b0;
                end else if (w_win_play) r_victoria <= 1'b1;
              end
            end
          end else if (btn_flag) begin
            if (!w_cur[REV_B]) r_board[r_i][r_j][FLAG_B] <= ~w_cur[FLAG_B];
          end else if (btn_up) begin
            if (r_i != 3'd0) r_i <= r_i - 3'd1;
          end else if (btn_down) begin
            if (r_i != 3'd7) r_i <= r_i + 3'd1;
          end else if (btn_left) begin
            if (r_j != 3'd0) r_j <= r_j - 3'd1;
          end else if (btn_right) begin
            if (r_j != 3'd7) r_j <= r_j + 3'd1;
          end
        end
        S_FLOOD: begin
          if (!r_idx[6]) begin
            for (int k = 0; k < 8; k++)
              if (w_fmask[k]) r_board[w_nb_r[k]][w_nb_c[k]][REV_B] <= 1'b1;
            r_rev <= r_rev + 7'(w_fcnt);
            if (|w_fmask) r_chg <= 1'b1;
            r_idx <= r_idx + 7'd1;
          end else if (r_chg) begin
            r_idx <= '0;
            r_chg <= 1'b0;
          end else if (w_win_flood) begin
            r_victoria <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tablero         = r_board;
  assign i_actual        = r_i;
  assign j_actual        = r_j;
  assign enable_derrota  = r_derrota;
  assign enable_victoria = r_victoria;
  assign busy            = (r_state == S_CLEAR) || (r_state == S_PLACE) ||
                           (r_state == S_COUNT) || (r_state == S_FLOOD);
endmodule

// File: tb/tb_tablero_ctrl.sv
// Bench for tablero_ctrl: directed scenarios plus randomized play against a board model.
module tb_tablero_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, use_map = 1'b0;
  logic [63:0] mine_map = '0;
  logic [15:0] seed = '0;
  logic [5:0]  num_minas = '0;
  logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_reveal = 0, btn_flag = 0;
  logic [7:0][7:0][6:0] tablero;
  logic [2:0] i_actual, j_actual;
  logic enable_derrota, enable_victoria, busy;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  tablero_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .use_map(use_map), .mine_map(mine_map),
    .seed(seed), .num_minas(num_minas), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .btn_reveal(btn_reveal), .btn_flag(btn_flag),
    .tablero(tablero), .i_actual(i_actual), .j_actual(j_actual),
    .enable_derrota(enable_derrota), .enable_victoria(enable_victoria), .busy(busy)
  );

  // ---------------- board model ----------------
  bit m_mine[64], m_flag[64], m_rev[64];
  int m_rev_n, m_mines, m_i, m_j;
  bit m_win, m_lose;

  function automatic int m_count(input int k);
    int r = k / 8, c = k % 8, n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < 8 && c+dc >= 0 && c+dc < 8 &&
            m_mine[(r+dr)*8 + c+dc]) n++;
    return n;
  endfunction

  function automatic logic [6:0] exp_cell(input int k);
    return {m_mine[k], m_flag[k], m_rev[k], 4'(m_count(k))};
  endfunction

  function automatic void m_clear();
    for (int k = 0; k < 64; k++) begin m_mine[k] = 0; m_flag[k] = 0; m_rev[k] = 0; end
    m_rev_n = 0; m_mines = 0; m_i = 0; m_j = 0; m_win = 0; m_lose = 0;
  endfunction

  function automatic void m_load_map(input logic [63:0] mp);
    m_clear();
    for (int k = 0; k < 64; k++) m_mine[k] = mp[k];
    m_mines = $countones(mp);
  endfunction

  function automatic int clamp_n(input int n);
    return (n == 0) ? 1 : (n > 10 ? 10 : n);
  endfunction

  function automatic void m_load_rand(input logic [15:0] sd, input int n);
    logic [15:0] s;
    int tgt, placed = 0, guard = 0;
    m_clear();
    tgt = clamp_n(n);
    s = (sd == 16'h0) ? 16'hACE1 : sd;
    while (placed < tgt && guard < 100000) begin
      if (!m_mine[s[5:0]]) begin m_mine[s[5:0]] = 1; placed++; end
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      guard++;
    end
    m_mines = tgt;
  endfunction

  // reveal closure: repeat until no zero cell has a hidden, unflagged, safe neighbour
  function automatic void m_flood();
    bit chg;
    do begin
      chg = 0;
      for (int k = 0; k < 64; k++)
        if (m_rev[k] && !m_mine[k] && m_count(k) == 0)
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
              int r = k/8 + dr, c = k%8 + dc;
              if (r >= 0 && r < 8 && c >= 0 && c < 8 && !m_rev[r*8+c] &&
                  !m_flag[r*8+c] && !m_mine[r*8+c]) begin
                m_rev[r*8+c] = 1; m_rev_n++; chg = 1;
              end
            end
    end while (chg);
  endfunction

  // b = {reveal, flag, up, down, left, right}
  function automatic void m_apply(input logic [5:0] b);
    int k = m_i*8 + m_j;
    if (m_win || m_lose) return;
    if (b[5]) begin
      if (!m_rev[k] && !m_flag[k]) begin
        m_rev[k] = 1;
        if (m_mine[k]) m_lose = 1;
        else begin
          m_rev_n++;
          if (m_count(k) == 0) m_flood();
          if (m_rev_n == 64 - m_mines) m_win = 1;
        end
      end
    end
    else if (b[4]) begin if (!m_rev[k]) m_flag[k] = !m_flag[k]; end
    else if (b[3]) begin if (m_i > 0) m_i--; end
    else if (b[2]) begin if (m_i < 7) m_i++; end
    else if (b[1]) begin if (m_j > 0) m_j--; end
    else if (b[0]) begin if (m_j < 7) m_j++; end
  endfunction

  // ---------------- drivers ----------------
  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin @(negedge clk); n++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles, required 0", busy, lim);
    end
  endtask

  task automatic press(input logic [5:0] b);
    @(negedge clk);
    {btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = b;
    @(negedge clk);
    {btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = '0;
    m_apply(b);
  endtask

  task automatic new_game(input logic um, input logic [63:0] mp, input logic [15:0] sd,
                          input logic [5:0] n);
    @(negedge clk);
    use_map = um; mine_map = mp; seed = sd; num_minas = n; start = 1;
    @(negedge clk);
    start = 0;
    if (um) m_load_map(mp); else m_load_rand(sd, int'(n));
    wait_idle(3000);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int bad = 0;
    #12;
    for (int k = 0; k < 64; k++) if (tablero[k/8][k%8] !== 7'd0) bad++;
    checks++;
    if (bad != 0 || i_actual !== 3'd0 || j_actual !== 3'd0 || busy !== 1'b0 ||
        enable_derrota !== 1'b0 || enable_victoria !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: %0d nonzero cells, cursor (%0d,%0d) busy %b der %b vic %b, required all 0",
               bad, i_actual, j_actual, busy, enable_derrota, enable_victoria);
    end
    @(negedge clk); rst_n = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b required 0", busy); end
  endtask

  task automatic test_map_count();
    int n = 0, bad = 0;
    @(negedge clk);
    use_map = 1; mine_map = 64'h1; start = 1;
    @(posedge clk); #1;
    start = 0;
    m_load_map(64'h1);
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 66) begin errors++; $display("FAIL busy_fall_edge: busy fell after %0d edges, required 66", n); end
    @(negedge clk);
    for (int k = 0; k < 64; k++) if (tablero[k/8][k%8] !== exp_cell(k)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL map_board: %0d cells differ from model", bad); end
    checks++;
    if (tablero[0][0] !== 7'h40 || tablero[0][1] !== 7'h01 || tablero[1][0] !== 7'h01 ||
        tablero[1][1] !== 7'h01 || tablero[2][2] !== 7'h00) begin
      errors++;
      $display("FAIL map_corner: got %h %h %h %h %h, required 40 01 01 01 00", tablero[0][0],
               tablero[0][1], tablero[1][0], tablero[1][1], tablero[2][2]);
    end
  endtask

  task automatic test_flood_win();
    int bad = 0, nrev = 0;
    repeat (7) press(6'b000100);
    repeat (7) press(6'b000001);
    checks++;
    if (i_actual !== 3'd7 || j_actual !== 3'd7) begin
      errors++; $display("FAIL flood_cursor: got (%0d,%0d) required (7,7)", i_actual, j_actual);
    end
    press(6'b100000);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL flood_busy: busy %b required 1", busy); end
    wait_idle(5000);
    for (int k = 0; k < 64; k++) begin
      if (tablero[k/8][k%8] !== exp_cell(k)) bad++;
      if (tablero[k/8][k%8][4]) nrev++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL flood_board: %0d cells differ from model", bad); end
    checks++;
    if (nrev != 63 || tablero[0][0][4] !== 1'b0) begin
      errors++; $display("FAIL flood_revealed: %0d revealed, [0][0].rev=%b, required 63 and 0", nrev, tablero[0][0][4]);
    end
    checks++;
    if (enable_victoria !== 1'b1 || enable_derrota !== 1'b0) begin
      errors++; $display("FAIL flood_win: vic %b der %b required 1 0", enable_victoria, enable_derrota);
    end
  endtask

  task automatic test_lose();
    int bad = 0;
    logic [63:0] mp;
    mp = 64'h1 << 27;
    new_game(1'b1, mp, 16'h0, 6'd0);
    repeat (3) press(6'b000100);
    repeat (3) press(6'b000001);
    press(6'b100000);
    checks++;
    if (enable_derrota !== 1'b1 || tablero[3][3][4] !== 1'b1 || enable_victoria !== 1'b0) begin
      errors++; $display("FAIL lose_hit: der %b rev %b vic %b required 1 1 0",
                         enable_derrota, tablero[3][3][4], enable_victoria);
    end
    press(6'b001000); press(6'b010000); press(6'b000010); press(6'b100000);
    for (int k = 0; k < 64; k++) if (tablero[k/8][k%8] !== exp_cell(k)) bad++;
    checks++;
    if (bad != 0 || i_actual !== 3'd3 || j_actual !== 3'd3 || enable_derrota !== 1'b1) begin
      errors++; $display("FAIL lose_hold: %0d cells differ, cursor (%0d,%0d) der %b, required 0 (3,3) 1",
                         bad, i_actual, j_actual, enable_derrota);
    end
  endtask

  task automatic test_flag();
    new_game(1'b1, 64'h1, 16'h0, 6'd0);
    press(6'b010000);
    checks++;
    if (tablero[0][0] !== 7'h60) begin errors++; $display("FAIL flag_set: got %h required 60", tablero[0][0]); end
    press(6'b100000);
    checks++;
    if (tablero[0][0] !== 7'h60 || enable_derrota !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flag_block_reveal: got %h der %b busy %b required 60 0 0",
                         tablero[0][0], enable_derrota, busy);
    end
    press(6'b010000);
    checks++;
    if (tablero[0][0] !== 7'h40) begin errors++; $display("FAIL flag_clear: got %h required 40", tablero[0][0]); end
  endtask

  task automatic test_cursor();
    new_game(1'b1, {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}, 16'h0, 6'd0);
    repeat (10) press(6'b000010);
    repeat (10) press(6'b001000);
    checks++;
    if (i_actual !== 3'd0 || j_actual !== 3'd0) begin
      errors++; $display("FAIL cursor_low: got (%0d,%0d) required (0,0)", i_actual, j_actual);
    end
    repeat (9) press(6'b000001);
    repeat (9) press(6'b000100);
    checks++;
    if (i_actual !== 3'd7 || j_actual !== 3'd7) begin
      errors++; $display("FAIL cursor_high: got (%0d,%0d) required (7,7)", i_actual, j_actual);
    end
  endtask

  task automatic test_random_place();
    logic [15:0] sds[5];
    logic [5:0]  ns[5];
    sds = '{16'h1234, 16'h0000, 16'($urandom), 16'($urandom), 16'($urandom)};
    ns  = '{6'd10, 6'd3, 6'd0, 6'd40, 6'($urandom_range(1, 10))};
    for (int t = 0; t < 5; t++) begin
      int bad = 0, nm = 0;
      new_game(1'b0, 64'h0, sds[t], ns[t]);
      for (int k = 0; k < 64; k++) begin
        if (tablero[k/8][k%8] !== exp_cell(k)) bad++;
        if (tablero[k/8][k%8][6]) nm++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand_board[%0d]: seed %h, %0d cells differ", t, sds[t], bad); end
      checks++;
      if (nm != clamp_n(int'(ns[t]))) begin
        errors++; $display("FAIL rand_count[%0d]: %0d mines, required %0d", t, nm, clamp_n(int'(ns[t])));
      end
    end
  endtask

  task automatic test_random_play();
    for (int g = 0; g < 4; g++) begin
      logic [63:0] mp = '0;
      int nm = $urandom_range(1, 12);
      for (int m = 0; m < nm; m++) mp[$urandom_range(0, 63)] = 1'b1;
      new_game(1'b1, mp, 16'h0, 6'd0);
      for (int a = 0; a < 50; a++) begin
        logic [5:0] b;
        int r = $urandom_range(0, 99), bad = 0;
        if (r < 20) b = 6'b100000;
        else if (r < 30) b = 6'b010000;
        else b = 6'(1 << $urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) b = b | 6'(1 << $urandom_range(0, 5));
        press(b);
        wait_idle(5000);
        for (int k = 0; k < 64; k++) if (tablero[k/8][k%8] !== exp_cell(k)) bad++;
        checks++;
        if (bad != 0 || i_actual !== 3'(m_i) || j_actual !== 3'(m_j) ||
            enable_derrota !== m_lose || enable_victoria !== m_win) begin
          errors++;
          $display("FAIL play[%0d.%0d]: btn %b, %0d cells differ, cursor (%0d,%0d)/(%0d,%0d), der %b/%b vic %b/%b",
                   g, a, b, bad, i_actual, j_actual, m_i, m_j, enable_derrota, m_lose, enable_victoria, m_win);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(negedge clk);
    use_map = 1; mine_map = 64'h8000_0100_0420_0001; start = 1;
    @(negedge clk);
    start = 0;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: busy %b required 1", busy); end
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 64; k++) if (tablero[k/8][k%8] !== 7'd0) bad++;
    checks++;
    if (bad != 0 || i_actual !== 3'd0 || j_actual !== 3'd0 || busy !== 1'b0 ||
        enable_derrota !== 1'b0 || enable_victoria !== 1'b0) begin
      errors++; $display("FAIL mid_reset: %0d nonzero cells, cursor (%0d,%0d) busy %b, required all 0",
                         bad, i_actual, j_actual, busy);
    end
    @(negedge clk); rst_n = 1;
    repeat (5) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 64; k++) if (tablero[k/8][k%8] !== 7'd0) bad++;
    checks++;
    if (bad != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: %0d nonzero cells busy %b, required 0 0", bad, busy);
    end
  endtask

  initial begin
    test_reset();
    test_map_count();
    test_flood_win();
    test_lose();
    test_flag();
    test_cursor();
    test_random_place();
    test_random_play();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tablero_ctrl.md
Name: tablero_ctrl

Overview:
- Game-state engine for the 8x8 minesweeper board. It places mines, computes neighbour counts, and handles cursor, reveal and flag actions, including flood-reveal of zero regions.
- It drives the board array, the cursor coordinates and the win/lose flags that feed the VGA pixel generator directly downstream.
- All board storage lives here. The pixel generator only reads it, combinationally.

Parameters:
- BOARD_N, 8, board side in cells; fixed at 8 by the 3-bit cursor ports.
- MAX_MINAS, 10, upper clamp applied to num_minas.
- DEFAULT_SEED, 16'hACE1, LFSR seed substituted when the seed input is 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; (re)starts a game from any state
- use_map  in  1  sampled on start; 1 = load mine_map instead of random placement
- mine_map  in  64  bit k = mine at row k/8, col k%8
- seed  in  16  LFSR seed, sampled on start
- num_minas  in  6  mine count, sampled on start; clamped to 1..MAX_MINAS
- btn_up, btn_down, btn_left, btn_right  in  1 each  one-cycle, pre-debounced cursor moves
- btn_reveal, btn_flag  in  1 each  one-cycle, pre-debounced actions
- tablero  out  [7:0][7:0] x 7  cell array indexed [row][col]
- i_actual, j_actual  out  3 each  cursor row, col
- enable_derrota  out  1  loss indicator
- enable_victoria  out  1  win indicator
- busy  out  1  high while initialising or flooding

Behaviour:
- Cell encoding:
  - bit6 = mine
  - bit5 = flag
  - bit4 = revealed
  - bits3:0 = adjacent-mine count, 0..8
- Reset (async):
  - All cells 7'd0.
  - Cursor (0,0).
  - enable_derrota, enable_victoria and busy all 0.
  - State IDLE; revealed counter 0.
- States: IDLE, CLEAR, PLACE, COUNT, PLAY, FLOOD, WIN, LOSE.
- start, accepted in any state:
  - Samples use_map, mine_map, seed and num_minas.
  - Moves to CLEAR at the next edge.
  - Clears both indicators and the revealed counter; cursor to (0,0).
- CLEAR, 1 cycle:
  - All cells zeroed.
  - If use_map: bit6 loaded from mine_map, then go to COUNT.
  - Otherwise: LFSR loaded with seed (or DEFAULT_SEED if seed is 0), then go to PLACE.
- PLACE:
  - LFSR is 16-bit Fibonacci, taps 16,14,13,11, and steps every cycle.
  - Each cycle, cell index lfsr[5:0] gets bit6 set if it is not already a mine; the placed counter increments.
  - Exits to COUNT when placed equals the clamped num_minas.
  - Duration depends on data; the bench must not rely on it.
- COUNT, 64 cycles:
  - Scans index 0..63, one cell per cycle.
  - Writes bits3:0 = number of mines among the up-to-8 in-board neighbours. Out-of-board neighbours count 0.
  - Then goes to PLAY.
  - With use_map, busy falls exactly 66 edges after the edge that sampled start.
- busy = 1 in CLEAR, PLACE, COUNT and FLOOD; 0 otherwise.
- PLAY, at most one action per cycle. Priority: reveal > flag > up > down > left > right.
- Moves:
  - Saturate at 0 and 7; no wrap.
- Flag:
  - Toggles bit5 on an unrevealed cell.
  - Ignored on a revealed cell.
- Reveal, target cell:
  - Revealed or flagged: ignored.
  - Mine: set bit4; enable_derrota = 1 at the next edge; go to LOSE.
  - Otherwise: set bit4 and increment the revealed counter.
  - If count == 0, go to FLOOD; else check for a win.
- FLOOD:
  - Repeated 64-cycle passes.
  - Each cell that is revealed, has count 0 and is not a mine reveals all unrevealed, unflagged, non-mine neighbours, incrementing the counter for each.
  - Ends after a pass with no change, then checks for a win.
  - Buttons ignored; start still restarts.
- Win: revealed counter == 64 - mines placed → enable_victoria = 1, state WIN.
- WIN/LOSE:
  - Hold outputs.
  - Ignore everything except start.
- Reset mid-operation (any state): immediate return to reset values; there are no partial boards.
- Revealed counter width: 7 bits, maximum 64.

Decomposition:
- buscaminas_pkg holds:
  - BOARD_N
  - cell bit indices (MINE_B=6, FLAG_B=5, REV_B=4, CNT_MSB=3)
  - cell_t (logic [6:0])
  - state enum
  - DEFAULT_SEED
- Sub-module lfsr16: load, enable, seed input, 16-bit state output. Reused by future random features.
- Neighbour counting and flood logic stay in tablero_ctrl as a shared 8-neighbour bounded-index function in the package.

Test Plan:
1. use_map, mine_map=64'h1 (mine at (0,0)), start → after busy falls:
   - tablero[0][0]=7'h40.
   - [0][1], [1][0] and [1][1] = 7'h01.
   - All other cells 7'h00.
   - busy low at edge 66.
2. Same map, cursor to (7,7), reveal:
   - busy high during flood.
   - Flood ends with 63 cells having bit4=1 and [0][0] bit4=0.
   - enable_victoria=1; enable_derrota=0.
3. mine_map with bit 27 set (mine at (3,3)), 3 down + 3 right, reveal → next edge: enable_derrota=1, tablero[3][3] bit4=1, later buttons ignored.
4. Flag at (0,0) → bit5=1; reveal there → no change; flag again → bit5=0.
5. Cursor: 10 left/up pulses from (0,0) → stays (0,0); 9 right + 9 down → (7,7).
6. Random mode, seed=16'h1234, num_minas=10 → exactly 10 cells with bit6, every count matches the bench model. Then assert rst_n low mid-COUNT on a restart → all cells 0, cursor (0,0), busy 0 asynchronously.
